// File: rtl/frame_line_capture_pkg.sv
// Shared video definitions for the line capture block: frame geometry,
// capture FSM state encoding and the per-pixel threshold test.
package frame_line_capture_pkg;

    localparam int X_SIZE         = 1280;  // pixels per line
    localparam int Y_SIZE         = 720;   // lines per frame
    localparam int WORDS_PER_LINE = 960;   // 3 words carry 4 pixels

    localparam logic [9:0] LAST_WORD_IDX = 10'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_WRITE    = 2'd2
    } cap_state_e;

    // A pixel is active when its zero-extended channel sum reaches the
    // threshold; 3*255 fits in 10 bits so the sum cannot overflow.
    function automatic logic pixel_active(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b,
                                          input logic [9:0] thr);
        logic [9:0] sum;
        sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
        return (sum >= thr);
    endfunction

endpackage

// File: rtl/frame_line_capture_pixel_unpacker.sv
// Realigns 24-bit pixels out of 32-bit little-endian stream words.
// Three consecutive words (phase 0,1,2) carry four pixels; bytes that
// straddle a word boundary are held in a small residual register.
//   phase 0: pixel from bytes 0..2, keep byte 3 (next b)
//   phase 1: pixel from residual b + bytes 0..1, keep bytes 2..3 (next b,g)
//   phase 2: pixel from residual b,g + byte 0, pixel from bytes 1..3
// pix_bits[0] is the only pixel when pix_two=0; when pix_two=1,
// pix_bits[1] is the earlier pixel and pix_bits[0] the later one.
module frame_line_capture_pixel_unpacker
    import frame_line_capture_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        word_en,
    input  logic [1:0]  phase,
    input  logic [31:0] word,
    input  logic [9:0]  threshold,
    output logic        pix_two,
    output logic [1:0]  pix_bits
);

    logic [7:0] byte0;
    logic [7:0] byte1;
    logic [7:0] byte2;
    logic [7:0] byte3;
    logic [7:0] res_b;
    logic [7:0] res_g;

    assign byte0 = word[7:0];
    assign byte1 = word[15:8];
    assign byte2 = word[23:16];
    assign byte3 = word[31:24];

    // Threshold the pixel(s) that complete in the current word.
    always_comb begin
        pix_two  = 1'b0;
        pix_bits = 2'b00;
        case (phase)
            2'd0: pix_bits[0] = pixel_active(byte2, byte1, byte0, threshold);
            2'd1: pix_bits[0] = pixel_active(byte1, byte0, res_b, threshold);
            default: begin
                pix_two     = 1'b1;
                pix_bits[1] = pixel_active(byte0, res_g, res_b, threshold);
                pix_bits[0] = pixel_active(byte3, byte2, byte1, threshold);
            end
        endcase
    end

    // Hold the bytes of a pixel that continues into the next word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_b <= '0;
            res_g <= '0;
        end else if (word_en) begin
            case (phase)
                2'd0: res_b <= byte3;
                2'd1: begin
                    res_b <= byte2;
                    res_g <= byte3;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_line_capture.sv
// Captures a video stream into 1-bit-per-pixel rows and writes each
// completed row to a BRAM port. Pixel 0 of a row lands in the MSB.
//
// Stream handshake: a word transfers on a rising edge where both
// in_stream_tvalid and in_stream_tready are high; tvalid low stalls every
// counter, and tready is low only in the single WRITE cycle per row and
// while reset is asserted.
module frame_line_capture
    import frame_line_capture_pkg::*;
#(
    parameter int unsigned Y_LINES = Y_SIZE
) (
    input  logic              in_stream_aclk,
    input  logic              periph_resetn,
    input  logic [31:0]       in_stream_tdata,
    input  logic [3:0]        in_stream_tkeep,
    input  logic              in_stream_tvalid,
    output logic              in_stream_tready,
    input  logic              in_stream_tlast,
    input  logic              in_stream_tuser,
    input  logic [9:0]        active_threshold,
    output logic [9:0]        line_wr_addr,
    output logic [X_SIZE-1:0] line_wr_data,
    output logic              line_wr_en,
    output logic              frame_done,
    output logic              sync_err,
    output logic [15:0]       frame_count,
    output logic [1:0]        state_dbg
);

    localparam logic [9:0] LAST_ROW = 10'(Y_LINES - 1);

    cap_state_e state;
    logic [9:0] word_cnt;
    logic [1:0] phase;
    logic [9:0] row;

    logic       accept;
    logic       take_word;
    logic       restart;
    logic [9:0] word_idx;
    logic [1:0] unpack_phase;
    logic [9:0] row_idx;
    logic       line_bad;
    logic       pix_two;
    logic [1:0] pix_bits;
    logic       unused_tkeep;

    // Byte enables carry no information for this stream.
    assign unused_tkeep = ^in_stream_tkeep;

    assign in_stream_tready = periph_resetn && (state != ST_WRITE);
    assign state_dbg        = state;

    // A word is consumed when it belongs to a line: any word in CAPTURE,
    // or the start-of-frame word while waiting for one.
    assign accept    = in_stream_tvalid && in_stream_tready;
    assign take_word = accept && ((state == ST_CAPTURE) ||
                                  ((state == ST_WAIT_SOF) && in_stream_tuser));
    // Every tuser word becomes word 0 of row 0 of a fresh frame.
    assign restart      = accept && in_stream_tuser;
    assign word_idx     = restart ? 10'd0 : word_cnt;
    assign unpack_phase = restart ? 2'd0  : phase;
    assign row_idx      = restart ? 10'd0 : row;
    // tlast must coincide exactly with the last word index of the line.
    assign line_bad     = in_stream_tlast != (word_idx == LAST_WORD_IDX);

    frame_line_capture_pixel_unpacker pixel_unpacker (
        .clk       (in_stream_aclk),
        .rst_n     (periph_resetn),
        .word_en   (take_word),
        .phase     (unpack_phase),
        .word      (in_stream_tdata),
        .threshold (active_threshold),
        .pix_two   (pix_two),
        .pix_bits  (pix_bits)
    );

    // Shift thresholded pixels in at the LSB; after 1280 pixels the first
    // pixel of the line has reached the MSB. A full line replaces all bits,
    // so abandoned partial lines never leak into a written row.
    always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            line_wr_data <= '0;
        end else if (take_word) begin
            if (pix_two) begin
                line_wr_data <= {line_wr_data[X_SIZE-3:0], pix_bits};
            end else begin
                line_wr_data <= {line_wr_data[X_SIZE-2:0], pix_bits[0]};
            end
        end
    end

    // Capture FSM: frame sync, word/phase/row counters and row write strobe.
    always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state        <= ST_WAIT_SOF;
            word_cnt     <= '0;
            phase        <= '0;
            row          <= '0;
            line_wr_addr <= '0;
            line_wr_en   <= 1'b0;
            frame_done   <= 1'b0;
            sync_err     <= 1'b0;
            frame_count  <= '0;
        end else begin
            line_wr_en <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_WAIT_SOF, ST_CAPTURE: begin
                    if (take_word) begin
                        if ((state == ST_CAPTURE) && in_stream_tuser) begin
                            sync_err <= 1'b1;
                        end
                        if (line_bad) begin
                            sync_err <= 1'b1;
                            state    <= ST_WAIT_SOF;
                            word_cnt <= '0;
                            phase    <= '0;
                            row      <= '0;
                        end else if (in_stream_tlast) begin
                            state        <= ST_WRITE;
                            line_wr_en   <= 1'b1;
                            line_wr_addr <= row_idx;
                            row          <= row_idx;
                            word_cnt     <= '0;
                            phase        <= '0;
                        end else begin
                            state    <= ST_CAPTURE;
                            word_cnt <= word_idx + 10'd1;
                            phase    <= (unpack_phase == 2'd2) ? 2'd0 : unpack_phase + 2'd1;
                            row      <= row_idx;
                        end
                    end
                end
                ST_WRITE: begin
                    if (row == LAST_ROW) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        row         <= '0;
                        state       <= ST_WAIT_SOF;
                    end else begin
                        row   <= row + 10'd1;
                        state <= ST_CAPTURE;
                    end
                end
                default: state <= ST_WAIT_SOF;
            endcase
        end
    end

endmodule
